serial_shift_engine: RTL

Multi-cycle universal shifter for 16-bit operands. It accepts a shift request through a start/busy/done handshake and shifts the operand one bit position per clock. It delivers the registered result together with a one-cycle done pulse. It gives the datapath a low-area, registered alternative to the combinational universal barrel shifter, using the same operand, shift-amount and direction encoding.

---
 rtl/serial_shift_engine_if.sv | 34 +++
 rtl/serial_shift_engine.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_shift_engine_if.sv
// serial_shift_engine_if
//   Request/response bundle for the multi-cycle universal shifter.
//   master (requester): drives start, A, Shift, ShiftChoice, ShiftType;
//                       observes busy, done, out.
//   slave  (shifter)  : the reverse direction of every signal.
//   Signals:
//     start        request strobe, only honoured while the shifter is idle
//     A[16:1]      operand
//     Shift[4:1]   shift amount 0..15
//     ShiftChoice  0 = left, 1 = right
//     ShiftType    00 logical, 01 arithmetic, 10 rotate, 11 logical
//     busy         request in progress
//     done         one-cycle completion pulse
//     out[16:1]    registered result
interface serial_shift_engine_if;
    logic        start;
    logic [16:1] A;
    logic [4:1]  Shift;
    logic        ShiftChoice;
    logic [2:1]  ShiftType;
    logic        busy;
    logic        done;
    logic [16:1] out;

    modport master (
        output start, A, Shift, ShiftChoice, ShiftType,
        input  busy, done, out
    );

    modport slave (
        input  start, A, Shift, ShiftChoice, ShiftType,
        output busy, done, out
    );
endinterface

// File: rtl/serial_shift_engine.sv
// serial_shift_engine
//   Multi-cycle universal shifter: shifts a 16-bit operand one position per
//   clock under a start/busy/done handshake and holds the result in a
//   register until the next completion.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; aborts any request in progress
//     bus    serial_shift_engine_if.slave (request inputs, busy/done/out)
module serial_shift_engine (
    input  logic                        clk,
    input  logic                        reset,
    serial_shift_engine_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg,  state_next;
    logic [16:1] work_reg,   work_next;
    logic [4:1]  count_reg,  count_next;
    logic        dir_reg,    dir_next;
    logic [2:1]  type_reg,   type_next;
    logic [16:1] out_reg,    out_next;

    // One-position step of the working register in both directions.
    logic [16:1] left_step;
    logic [16:1] right_step;
    logic [16:1] step_value;
    logic        is_rotate;
    logic        is_arith;
    logic        fill_low;
    logic        fill_high;

    // Code 11 is reserved and falls through to logical behaviour.
    assign is_rotate = (type_reg == 2'b10);
    assign is_arith  = (type_reg == 2'b01);

    // Bit entering position 1 on a left step: only a rotate brings data in.
    assign fill_low  = is_rotate ? work_reg[16] : 1'b0;
    // Bit entering position 16 on a right step: rotate wraps bit 1,
    // arithmetic replicates the sign bit.
    assign fill_high = is_rotate ? work_reg[1] :
                       is_arith  ? work_reg[16] : 1'b0;

    generate
        for (genvar gi = 2; gi <= 16; gi++) begin : g_left
            assign left_step[gi] = work_reg[gi-1];
        end
        for (genvar gi = 1; gi <= 15; gi++) begin : g_right
            assign right_step[gi] = work_reg[gi+1];
        end
    endgenerate

    assign left_step[1]   = fill_low;
    assign right_step[16] = fill_high;
    assign step_value     = dir_reg ? right_step : left_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            type_reg  <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            type_reg  <= type_next;
            out_reg   <= out_next;
        end
    end

    // out_reg is loaded on the edge that enters DONE so the result is
    // already valid during the done cycle.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        dir_next   = dir_reg;
        type_next  = type_reg;
        out_next   = out_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    work_next  = bus.A;
                    count_next = bus.Shift;
                    dir_next   = bus.ShiftChoice;
                    type_next  = bus.ShiftType;
                    if (bus.Shift == 4'd0) begin
                        out_next   = bus.A;
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_next  = step_value;
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    out_next   = step_value;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
    assign bus.out  = out_reg;

endmodule
